// File: rtl/hydra_pkg.sv
// Shared definitions for the hydra packet path: header field positions,
// read-sink state encoding and error flag bit indices.
package hydra_pkg;

    localparam int LEN_MSB  = 15;
    localparam int LEN_LSB  = 7;
    localparam int PRIO_MSB = 6;
    localparam int PRIO_LSB = 4;
    localparam int PORT_MSB = 3;
    localparam int PORT_LSB = 0;

    localparam int F_LEN   = 0;
    localparam int F_PORT  = 1;
    localparam int F_PAT   = 2;
    localparam int F_PROTO = 3;
    localparam int F_TMO   = 4;
    localparam int NFLAGS  = 5;

    typedef enum logic [2:0] {
        S_GAP,
        S_REQ,
        S_WAIT_SOP,
        S_HDR,
        S_DATA
    } state_t;

endpackage

// File: rtl/hydra_hdr_decode.sv
// Combinational split of a 16-bit hydra header word.
// Ports: hdr (header word in), len / prio / dest (fields out).
module hydra_hdr_decode
    import hydra_pkg::*;
(
    input  logic [15:0]                hdr,
    output logic [LEN_MSB-LEN_LSB:0]   len,
    output logic [PRIO_MSB-PRIO_LSB:0] prio,
    output logic [PORT_MSB-PORT_LSB:0] dest
);

    assign len  = hdr[LEN_MSB:LEN_LSB];
    assign prio = hdr[PRIO_MSB:PRIO_LSB];
    assign dest = hdr[PORT_MSB:PORT_LSB];

endmodule

// File: rtl/hydra_rd_sink.sv
// Read-side packet consumer for one hydra output port: requests packets,
// parses the header, checks length/port/pattern and counts good/bad packets.
// Ports: clk, rst (async, active-high), en, chk_pattern;
//        ready/busy (request side); rd_sop/rd_vld/rd_data/rd_eop (stream in);
//        pkt_cnt, err_cnt, err_flags, last_prio, last_len (status out).
module hydra_rd_sink
    import hydra_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int REQ_GAP = 16,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              chk_pattern,
    output logic              ready,
    input  logic              rd_sop,
    input  logic              rd_vld,
    input  logic [15:0]       rd_data,
    input  logic              rd_eop,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [NFLAGS-1:0] err_flags,
    output logic [2:0]        last_prio,
    output logic [8:0]        last_len
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    G_LAST = 8'(REQ_GAP - 1);
    localparam logic [3:0]    PORT   = 4'(PORT_ID);

    state_t            state;
    logic              live;
    logic [7:0]        gap_cnt;
    logic [TW-1:0]     tcnt;
    logic [8:0]        bcnt;
    logic [NFLAGS-1:0] pend;
    logic              chk_en;

    logic [8:0]        hd_len;
    logic [2:0]        hd_prio;
    logic [3:0]        hd_dest;

    hydra_hdr_decode u_dec (
        .hdr  (rd_data),
        .len  (hd_len),
        .prio (hd_prio),
        .dest (hd_dest)
    );

    logic              idle_st;
    logic              pkt_st;
    logic              tmo;
    logic              close;
    logic              ok_inc;
    logic [1:0]        err_inc;
    logic [NFLAGS-1:0] ev_flags;
    logic [9:0]        exp_beats;
    logic [CNT_W:0]    err_sum;

    assign idle_st = (state == S_GAP) || (state == S_REQ)
                  || (state == S_WAIT_SOP);
    assign pkt_st  = (state == S_HDR) || (state == S_DATA);
    // sop wins over timeout when both land in the same cycle
    assign tmo     = (state == S_WAIT_SOP) && !rd_sop && (tcnt == T_LAST);
    assign exp_beats = {1'b0, last_len} + 10'd1;
    assign err_sum   = {1'b0, err_cnt} + (CNT_W+1)'(err_inc);

    always_comb begin
        ev_flags = '0;
        close    = 1'b0;
        ok_inc   = 1'b0;
        err_inc  = 2'd0;
        if (idle_st && (rd_vld || rd_eop))
            ev_flags[F_PROTO] = 1'b1;
        if (tmo)
            ev_flags[F_TMO] = 1'b1;
        if (pkt_st && rd_sop) begin
            close = 1'b1;
            ev_flags = pend;
            ev_flags[F_PROTO] = 1'b1;
        end else if (state == S_HDR && rd_eop) begin
            close = 1'b1;
            ev_flags = pend;
            ev_flags[F_PROTO] = 1'b1;
        end else if (state == S_DATA && rd_eop) begin
            close = 1'b1;
            ev_flags = pend;
            if ({1'b0, bcnt} != exp_beats)
                ev_flags[F_LEN] = 1'b1;
        end
        if (close) begin
            if (ev_flags == '0) ok_inc = 1'b1;
            else                err_inc = 2'd1;
        end else begin
            // a stray beat and a timeout can coincide in WAIT_SOP
            err_inc = 2'(ev_flags[F_PROTO]) + 2'(ev_flags[F_TMO]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_GAP;
            live      <= 1'b0;
            gap_cnt   <= '0;
            tcnt      <= '0;
            bcnt      <= '0;
            pend      <= '0;
            chk_en    <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            err_flags <= '0;
            last_prio <= '0;
            last_len  <= '0;
        end else begin
            // first edge after reset release only arms the gap counter
            live      <= 1'b1;
            ready     <= 1'b0;
            err_flags <= err_flags | ev_flags;
            err_cnt   <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            if (ok_inc && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            unique case (state)
                S_GAP: begin
                    if (en && live) begin
                        if (gap_cnt == G_LAST) begin
                            state   <= S_REQ;
                            ready   <= 1'b1;
                            busy    <= 1'b1;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                S_REQ: begin
                    tcnt  <= '0;
                    state <= S_WAIT_SOP;
                end
                S_WAIT_SOP: begin
                    if (rd_sop) begin
                        state  <= S_HDR;
                        pend   <= '0;
                        chk_en <= chk_pattern;
                    end else if (tmo) begin
                        state   <= S_GAP;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_HDR, S_DATA: begin
                    if (rd_sop) begin
                        state  <= S_HDR;
                        pend   <= '0;
                        chk_en <= chk_pattern;
                    end else if (rd_eop) begin
                        state   <= S_GAP;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else if (rd_vld) begin
                        if (state == S_HDR) begin
                            last_len     <= hd_len;
                            last_prio    <= hd_prio;
                            pend[F_PORT] <= (hd_dest != PORT);
                            bcnt         <= '0;
                            state        <= S_DATA;
                        end else begin
                            if (bcnt != 9'h1FF)
                                bcnt <= bcnt + 9'd1;
                            if (chk_en && rd_data != 16'(bcnt) + 16'd1)
                                pend[F_PAT] <= 1'b1;
                        end
                    end
                end
                default: state <= S_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_hydra_rd_sink.sv
// Self-checking bench for hydra_rd_sink: directed scenarios plus a
// randomized packet mix predicted by a packet-level outcome model.
module tb_hydra_rd_sink;

    localparam int PORT_ID = 2;
    localparam int REQ_GAP = 16;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             chk_pattern = 1'b0;
    logic             rd_sop = 1'b0;
    logic             rd_vld = 1'b0;
    logic             rd_eop = 1'b0;
    logic [15:0]      rd_data = '0;
    logic             ready;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [4:0]       err_flags;
    logic [2:0]       last_prio;
    logic [8:0]       last_len;

    int         checks = 0;
    int         errors = 0;
    int         exp_pkt = 0;
    int         exp_err = 0;
    logic [4:0] exp_flags = '0;
    int         exp_len = 0;
    int         exp_prio = 0;

    always #5 clk = ~clk;

    hydra_rd_sink #(
        .PORT_ID (PORT_ID),
        .REQ_GAP (REQ_GAP),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .chk_pattern (chk_pattern),
        .ready       (ready),
        .rd_sop      (rd_sop),
        .rd_vld      (rd_vld),
        .rd_data     (rd_data),
        .rd_eop      (rd_eop),
        .busy        (busy),
        .pkt_cnt     (pkt_cnt),
        .err_cnt     (err_cnt),
        .err_flags   (err_flags),
        .last_prio   (last_prio),
        .last_len    (last_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int gmax);
        int g;
        g = $urandom_range(gmax, 0);
        repeat (g) tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 2000);
        chk("ready_seen", ready, 1);
    endtask

    // Reset taken at a negedge; outputs must clear immediately.
    task automatic do_reset(input string tag);
        rd_sop = 0; rd_vld = 0; rd_eop = 0; en = 1;
        rst = 1;
        #1;
        chk({tag, ".ready"}, ready, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".pkt"}, pkt_cnt, 0);
        chk({tag, ".err"}, err_cnt, 0);
        chk({tag, ".flags"}, err_flags, 0);
        chk({tag, ".prio"}, last_prio, 0);
        chk({tag, ".len"}, last_len, 0);
        tick();
        rst = 0;
        exp_pkt = 0; exp_err = 0; exp_flags = '0;
        exp_len = 0; exp_prio = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pkt"}, pkt_cnt, exp_pkt);
        chk({tag, ".err"}, err_cnt, exp_err);
        chk({tag, ".flags"}, err_flags, exp_flags);
        chk({tag, ".len"}, last_len, exp_len);
        chk({tag, ".prio"}, last_prio, exp_prio);
        chk({tag, ".busy"}, busy, 0);
    endtask

    // Outcome of one well-framed packet from its descriptor.
    task automatic model_pkt(input int len, input int dest, input int nbeats,
                             input int bad, input bit chkp);
        logic [4:0] f;
        f = '0;
        if (nbeats != len + 1) f[0] = 1'b1;
        if (dest != PORT_ID) f[1] = 1'b1;
        if (chkp && bad >= 0 && bad < nbeats) f[2] = 1'b1;
        if (f == '0) exp_pkt++;
        else exp_err++;
        exp_flags |= f;
    endtask

    task automatic stream(input int len, input int prio, input int dest,
                          input int nbeats, input int bad, input bit chkp,
                          input int gmax, input bit do_eop);
        rd_sop = 1; chk_pattern = chkp;
        tick();
        rd_sop = 0;
        idle(gmax);
        rd_vld = 1;
        rd_data = {9'(len), 3'(prio), 4'(dest)};
        tick();
        rd_vld = 0;
        exp_len = len; exp_prio = prio;
        chk("hdr.busy", busy, 1);
        chk("hdr.len", last_len, len);
        for (int k = 0; k < nbeats; k++) begin
            idle(gmax);
            rd_vld = 1;
            rd_data = (k == bad) ? 16'hFFFF : 16'(k + 1);
            tick();
            rd_vld = 0;
        end
        if (do_eop) begin
            idle(gmax);
            rd_eop = 1;
            tick();
            rd_eop = 0;
        end
    endtask

    initial begin
        int n;
        int len, prio, dest, nb, bad;
        bit cp;

        tick();

        // nominal packet and request spacing
        do_reset("rst0");
        wait_ready(n);
        chk("first_ready_lat", n, REQ_GAP + 1);
        tick();
        stream(31, 0, 2, 32, -1, 1, 0, 1);
        model_pkt(31, 2, 32, -1, 1);
        check_all("nominal");
        chk("nominal.pkt1", pkt_cnt, 1);
        wait_ready(n);
        chk("eop_to_ready", n + 1, REQ_GAP + 1);

        // short payload
        do_reset("rst_len");
        wait_ready(n);
        tick();
        stream(31, 0, 2, 31, -1, 1, 0, 1);
        model_pkt(31, 2, 31, -1, 1);
        check_all("len_err");
        chk("len_err.flags1", err_flags, 5'b00001);

        // wrong destination
        do_reset("rst_port");
        wait_ready(n);
        tick();
        stream(31, 0, 3, 32, -1, 1, 1, 1);
        model_pkt(31, 3, 32, -1, 1);
        check_all("port_err");
        chk("port_err.flags2", err_flags, 5'b00010);

        // corrupted payload word, checked then unchecked; en hold
        do_reset("rst_pat");
        wait_ready(n);
        tick();
        stream(31, 0, 2, 32, 5, 1, 1, 1);
        model_pkt(31, 2, 32, 5, 1);
        check_all("pat_err");
        chk("pat_err.flags4", err_flags, 5'b00100);
        en = 0;
        repeat (5) tick();
        en = 1;
        wait_ready(n);
        chk("en_hold_lat", n + 6, REQ_GAP + 1 + 5);
        tick();
        stream(31, 0, 2, 32, 5, 0, 1, 1);
        model_pkt(31, 2, 32, 5, 0);
        check_all("pat_off");

        // no response to the request
        do_reset("rst_tmo");
        wait_ready(n);
        for (int i = 1; i <= TIMEOUT; i++) tick();
        chk("tmo_early.flag", err_flags[4], 0);
        chk("tmo_early.busy", busy, 1);
        tick();
        exp_err++;
        exp_flags |= 5'b10000;
        check_all("tmo");
        wait_ready(n);
        chk("tmo_to_ready", n, REQ_GAP);

        // protocol errors and recovery
        do_reset("rst_proto");
        repeat (3) tick();
        rd_vld = 1;
        tick();
        rd_vld = 0;
        exp_err++;
        exp_flags |= 5'b01000;
        check_all("vld_in_gap");
        wait_ready(n);
        chk("gap_unaffected", n + 4, REQ_GAP + 1);
        tick();
        rd_eop = 1;
        tick();
        rd_eop = 0;
        exp_err++;
        chk("eop_in_wait.err", err_cnt, exp_err);
        chk("eop_in_wait.busy", busy, 1);
        stream(31, 2, 2, 10, -1, 1, 1, 0);
        exp_err++;
        stream(20, 5, 2, 21, -1, 1, 1, 1);
        model_pkt(20, 2, 21, -1, 1);
        check_all("sop_mid_data");

        // reset in the middle of a packet
        do_reset("rst_mid0");
        wait_ready(n);
        tick();
        stream(31, 0, 2, 10, -1, 1, 0, 0);
        do_reset("rst_mid");
        wait_ready(n);
        chk("rst_mid.ready_lat", n, REQ_GAP + 1);
        tick();
        stream(31, 1, 2, 32, -1, 1, 1, 1);
        model_pkt(31, 2, 32, -1, 1);
        check_all("after_rst");

        // random packet mix
        do_reset("rst_rand");
        wait_ready(n);
        for (int p = 0; p < 25; p++) begin
            tick();
            len  = $urandom_range(40, 0);
            prio = $urandom_range(7, 0);
            dest = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0) : 2;
            nb   = len + 1;
            if ($urandom_range(3, 0) == 0)
                nb = nb + (($urandom_range(1, 0) == 1) ? 1 : -1);
            cp   = 1'($urandom_range(1, 0));
            bad  = ($urandom_range(2, 0) == 0) ? $urandom_range(len, 0) : -1;
            stream(len, prio, dest, nb, bad, cp, 2, 1);
            model_pkt(len, dest, nb, bad, cp);
            check_all("rand");
            wait_ready(n);
            chk("rand.gap", n + 1, REQ_GAP + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hydra_rd_sink.md
Name: hydra_rd_sink

Overview:
- Per-port read-side consumer for one hydra output port: requests packets with `ready`, accepts the `rd_sop`/`rd_vld`/`rd_data`/`rd_eop` stream and parses the 16-bit header word.
- Checks payload length, destination port and payload pattern; counts good and bad packets.
- Instantiated once per output port, in system benches and in the on-board self-test alongside the write-side packet generator.

Parameters:
- PORT_ID, 0, index of the output port this sink serves; compared against header bits [3:0].
- REQ_GAP, 16, idle cycles between end of one packet (or enable) and the next `ready` pulse; legal range 1..255.
- TIMEOUT, 1023, maximum cycles from `ready` pulse to `rd_sop`; must be ≥1.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  enable; when low, no new request is issued.
- chk_pattern  input  1  enables the payload pattern check; sampled at `rd_sop`.
- ready  output  1  single-cycle packet request to hydra.
- rd_sop  input  1  start-of-packet pulse; carries no data.
- rd_vld  input  1  data beat valid.
- rd_data  input  16  beat data; the first beat is the header: [15:7] len, [6:4] prio, [3:0] dest port.
- rd_eop  input  1  end-of-packet pulse; `rd_vld` is low in the same cycle.
- busy  output  1  high from the `ready` pulse until the packet closes.
- pkt_cnt  output  CNT_W  number of packets closed without error.
- err_cnt  output  CNT_W  number of packets or events closed with an error.
- err_flags  output  5  sticky flags: [0] length, [1] port, [2] pattern, [3] protocol, [4] timeout.
- last_prio  output  3  priority of the most recent header.
- last_len  output  9  len field of the most recent header.

Behaviour:
- Reset values: all outputs 0. State = GAP with the gap counter at 0.
- Header and payload:
  - Expected payload beat count = len + 1 (len = 31 gives 32 payload beats).
  - Expected payload word k (k from 0) = k + 1, 16-bit truncated.
- States and transitions:
  - GAP: counts en-high cycles. At REQ_GAP it moves to REQ. When `en` is low the counter holds.
  - REQ: drives `ready` = 1 for exactly one cycle, sets `busy`, clears the timeout counter, then goes to WAIT_SOP.
  - WAIT_SOP: on `rd_sop` go to HDR. If the timeout counter reaches TIMEOUT, set flag[4], increment `err_cnt`, go to GAP.
  - HDR: the first `rd_vld` beat latches `last_len`, `last_prio` and dest, clears the beat counter, goes to DATA.
    - If dest ≠ PORT_ID, flag[1] is pending.
    - `rd_eop` before the header: flag[3], close as error.
  - DATA: each `rd_vld` increments the beat counter (saturates at 511). If the pattern check is on and the word mismatches, flag[2] is pending. On `rd_eop`, close.
    - Length error if beat counter ≠ len + 1.
    - Closing adds 1 to `pkt_cnt` if no flag is pending, else adds 1 to `err_cnt`.
    - In both cases: OR the pending flags into `err_flags`, clear `busy`, go to GAP with the gap counter at 0.
- Gaps: `rd_vld` gaps of any length are legal in HDR and DATA.
- Protocol errors (flag[3], one `err_cnt` increment per event):
  - `rd_vld` or `rd_eop` in GAP, REQ or WAIT_SOP: event is ignored apart from the flag and count.
  - `rd_sop` in HDR or DATA: the current packet closes as error and the new packet starts in HDR the same cycle.
- Counters saturate at all-ones.
- `err_flags` clear only on `rst`.
- `rst` mid-packet: everything returns to reset values immediately; a packet in flight is neither counted nor flagged.
- After `rst`, the first `ready` appears no earlier than REQ_GAP + 1 cycles after `rst` deasserts, with `en` held high.

Decomposition:
- Shared package `hydra_pkg` holds:
  - header field constants: LEN_MSB = 15, LEN_LSB = 7, PRIO_MSB = 6, PRIO_LSB = 4, PORT_MSB = 3, PORT_LSB = 0;
  - the state enum type;
  - the error flag bit indices.
- One sub-module, `hydra_hdr_decode`: purely combinational header split into len, prio and dest. The write-side generator reuses it for header build checks. Everything else stays in one module.

Test Plan:
- Nominal: PORT_ID = 2, en = 1, REQ_GAP = 16. Respond to `ready` with sop, header 0x0F82 (len 31, prio 0, dest 2), payload 1..32 back-to-back, then eop → `pkt_cnt` = 1, `err_flags` = 0, `last_len` = 31, next `ready` exactly 17 cycles after eop.
- Length error: same header, 31 payload beats then eop → `err_cnt` = 1, `err_flags` = 5'b00001, `pkt_cnt` = 0.
- Port and pattern errors:
  - header dest 3 with PORT_ID = 2 → flag[1];
  - separately, with `chk_pattern` = 1, payload word 5 = 0xFFFF → flag[2]; with `chk_pattern` = 0 the same packet → `pkt_cnt` increments.
- Timeout: TIMEOUT = 100, no sop after `ready` → flag[4] at cycle 100 after `ready`, `busy` = 0, a new `ready` follows REQ_GAP cycles later.
- Protocol error and recovery:
  - `rd_vld` in GAP → flag[3];
  - second `rd_sop` mid-DATA → first packet counted in `err_cnt`; the second, valid packet → `pkt_cnt` + 1.
- Reset mid-packet: assert `rst` at payload beat 10 → all outputs 0 the same cycle. After release, a full valid packet → `pkt_cnt` = 1 and `err_cnt` = 0.
